// File: rtl/arb_mux_n_pkg.sv
// arb_mux_n_pkg
//   Shared definitions for the arb_mux_n slice: the arbitration mode type and
//   the helper that derives the channel-index width from the channel count.
//   No ports.
package arb_mux_n_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,  // lowest index always wins
    ARB_RR    = 1'b1   // search starts one past the previous winner
  } arb_mode_e;

  // Index width for n channels; kept at least 1 bit so vectors stay legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// arb_mux_n_if
//   Producer/consumer handshake bundle for arb_mux_n.
//   in_valid  [N]        per-channel request
//   in_data   [N*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N]        one-hot-or-zero transfer grant
//   out_valid            output register holds a word
//   out_data  [WIDTH]    registered winning word
//   out_sel   [SELW]     registered index of the winning channel
//   out_ready            consumer accepts the word
//   Modports: slave (the mux), master (producers + consumer side).
interface arb_mux_n_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) ();
  localparam int unsigned SELW = arb_mux_n_pkg::sel_width(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_mux_n_rr_arbiter.sv
// rr_arbiter
//   Combinational rotating-priority arbiter.
//   req  [N]     request vector
//   ptr  [SELW]  highest-priority index for this cycle (must be < N)
//   gnt  [N]     one-hot grant, zero when no request
//   gidx [SELW]  index of the granted request, zero when none
module rr_arbiter
  import arb_mux_n_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gidx
);
  localparam int unsigned DW = 2 * N;

  logic [DW-1:0] w_dreq;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_masked;
  logic [DW-1:0] w_dgnt;

  // Two back-to-back copies of req; masking off everything below ptr leaves
  // the upper copy to supply the wrapped-around candidates. The lowest set
  // bit of the masked vector is the winner, folded back into N bits.
  always_comb begin
    w_dreq   = {req, req};
    w_mask   = ~((DW'(1) << ptr) - DW'(1));
    w_masked = w_dreq & w_mask;
    w_dgnt   = w_masked & (~w_masked + DW'(1));
    gnt      = w_dgnt[N-1:0] | w_dgnt[DW-1:N];
    gidx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) gidx = SELW'(i);
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n
//   N:1 valid/ready mux with round-robin or fixed-priority arbitration and a
//   single registered output stage. The output register refills on the same
//   edge it drains, so a steady 1 word/cycle flows while out_ready stays high.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  arb_mux_n_if.slave: in_valid/in_data/in_ready (producers),
//        out_valid/out_data/out_sel/out_ready (consumer)
//   RR_MODE: 1 = round-robin, 0 = fixed priority (lowest index wins)
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N       = 4,
  parameter int unsigned RR_MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  arb_mux_n_if.slave  bus
);
  localparam int unsigned SELW = sel_width(N);
  localparam arb_mode_e   MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_any;
  logic [N-1:0]     w_gnt;
  logic [SELW-1:0]  w_gidx;
  logic [SELW-1:0]  w_arb_ptr;
  logic [SELW-1:0]  w_ptr_next;
  logic [WIDTH-1:0] w_chan [N];

  // Register may take a new word when empty or when its current word leaves.
  assign w_load    = ~r_valid | bus.out_ready;
  assign w_any     = |bus.in_valid;
  assign w_arb_ptr = (MODE == ARB_RR) ? r_ptr : '0;

  rr_arbiter #(.N(N)) u_arb (
    .req  (bus.in_valid),
    .ptr  (w_arb_ptr),
    .gnt  (w_gnt),
    .gidx (w_gidx)
  );

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign w_chan[g] = bus.in_data[g*WIDTH +: WIDTH];
  end

  // Explicit wrap so ptr stays below N when N is not a power of two.
  assign w_ptr_next = (w_gidx == SELW'(N - 1)) ? '0 : w_gidx + SELW'(1);

  // Gated by rst so no producer sees a handshake while the register is held clear.
  assign bus.in_ready = (w_load & ~rst) ? w_gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_chan[w_gidx];
        r_sel   <= w_gidx;
        if (MODE == ARB_RR) r_ptr <= w_ptr_next;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

endmodule
